timer_scheduler: RTL
====================

Name: timer_scheduler

Overview:
- Round-robin scheduler sharing the single seconds timer (4-second round counter) among N requesters, e.g. robot action FSMs that each need timed waits.
- Drives the timer's count enable and consumes its finish level and 2-bit second index.
- Grants exclusive use for a requested number of 4-second rounds, then pulses done to the owner.
- Sits between the action FSMs and the timer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RW, 4, width of the round-count field per requester.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester level request; must be held until done or cancel
- req_rounds  input  N_REQ*RW  rounds per requester, slice i = bits [i*RW +: RW]
- abort  input  1  cancel the current grant
- timer_finish  input  1  timer finish level (high for one second after each 4-second round)
- timer_detail  input  2  timer second index 0..3
- timer_en  output  1  timer count enable
- grant  output  N_REQ  one-hot current owner, 0 when none
- done  output  N_REQ  one-cycle completion pulse to the owner
- busy  output  1  high whenever state is not IDLE
- remaining  output  RW  rounds left for the current owner
- progress  output  2  timer_detail while RUN, else 0

Behaviour:
- Reset: one clock and rst_n only; reset is asynchronous and active-low. While rst_n is low:
  - state=IDLE, timer_en=0, grant=0, done=0, busy=0, remaining=0, rr_ptr=0, fin_q=0.
  - Reset mid-RUN drops timer_en immediately; no done pulse.
- States: IDLE, RUN, ZERO, DONE, GAP. All outputs are registered except progress, which is combinational from state and timer_detail.
- IDLE:
  - If any req bit is set, select the first set index scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Latch idx; latch rounds = req_rounds slice idx.
  - Next edge, rounds != 0: state=RUN, grant[idx]=1, timer_en=1, remaining=rounds.
  - Next edge, rounds == 0: state=ZERO, grant[idx]=1, timer_en stays 0.
  - Request-to-grant latency is 1 cycle.
- RUN:
  - fin_q registers timer_finish every cycle; fin_rise = timer_finish & ~fin_q.
  - On fin_rise: remaining-1. If remaining was 1, go to DONE.
  - Cancel: abort=1 or req[idx]=0. Go to GAP with timer_en=0, grant=0, remaining=0, and no done pulse.
  - Cancel beats fin_rise in the same cycle.
  - rr_ptr does not advance on cancel.
- ZERO: one cycle, then to DONE. Zero-round requests complete without touching the timer.
- DONE: one cycle.
  - done[idx]=1; grant=0; timer_en=0; remaining=0.
  - rr_ptr = (idx+1) mod N_REQ.
  - Then to GAP.
- GAP: one cycle with timer_en=0, then to IDLE.
  - Guarantees ≥2 consecutive low-enable cycles so the timer clears its count, second index and finish level before the next grant.
- Requests arriving during RUN/ZERO/DONE/GAP wait; they are evaluated only in IDLE.
- req_rounds changes after the grant are ignored.
- A requester may re-request immediately after done. It is served after the other pending requesters because of the rr_ptr advance.
- remaining never wraps: decrement happens only when the value is ≥1.
- done is never asserted in the same cycle as grant.
- At most one grant bit is set at any time.

Test Plan:
- Single request, rounds=2: req[1]=1 with rounds=2.
  - Cycle+1: grant=0010, timer_en=1, remaining=2.
  - After two fin_rise: done[1] pulses for exactly 1 cycle; remaining=0; timer_en low for ≥2 cycles; busy falls 2 cycles after done.
- Round-robin: req=1111 held, all rounds=1, rr_ptr=0.
  - Grants occur in order 0,1,2,3,0.
  - Each done is followed by GAP before the next grant.
- Cancel: req[2]=1, rounds=3.
  - abort asserted after 1 fin_rise → grant=0, timer_en=0, no done, remaining=0.
  - Same scenario with req[2] dropped instead of abort → identical response.
  - Next IDLE rescans from the same rr_ptr.
- Abort and finish collide: abort and fin_rise in the same cycle with remaining=1 → no done pulse; state goes to GAP.
- Zero rounds: req[0]=1, rounds=0 → grant=0001 for 1 cycle, then done[0] pulse; timer_en never high.
- Async reset mid-RUN: drop rst_n during RUN with remaining=3.
  - All outputs reach their reset values without waiting for a clock edge.
  - After release with req still held, grant restarts from rr_ptr=0 with remaining reloaded.
  - A held timer_finish high at release does not count as a fin_rise before the first grant.

Source files
------------

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin arbiter that lends the shared 4-second round timer
// to one requester at a time for a requested number of rounds.
module timer_scheduler #(
    parameter int N_REQ = 4,
    parameter int RW    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*RW-1:0] req_rounds,
    input  logic                abort,
    input  logic                timer_finish,
    input  logic [1:0]          timer_detail,
    output logic                timer_en,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [RW-1:0]       remaining,
    output logic [1:0]          progress
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [2:0] {IDLE, RUN, ZERO, DONE, GAP} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n, rr_ptr, rr_n, sel;
    logic [N_REQ-1:0] grant_n, done_n;
    logic [RW-1:0] remaining_n, rounds;
    logic timer_en_n, fin_q, fin_rise, found, cancel;

    always_comb begin
        found = 1'b0;
        sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                sel = IW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign rounds   = req_rounds[sel*RW +: RW];
    assign fin_rise = timer_finish & ~fin_q;
    assign cancel   = abort | ~req[idx];
    assign progress = (state == RUN) ? timer_detail : 2'd0;

    always_comb begin
        state_n = state;
        idx_n = idx;
        rr_n = rr_ptr;
        grant_n = grant;
        done_n = '0;
        timer_en_n = timer_en;
        remaining_n = remaining;
        case (state)
            IDLE: if (found) begin
                idx_n = sel;
                grant_n = N_REQ'(1) << sel;
                remaining_n = rounds;
                timer_en_n = |rounds;
                state_n = (|rounds) ? RUN : ZERO;
            end
            RUN: if (cancel) begin
                state_n = GAP;
                grant_n = '0;
                timer_en_n = 1'b0;
                remaining_n = '0;
            end else if (fin_rise && remaining != '0) begin
                remaining_n = remaining - 1'b1;
                if (remaining == RW'(1)) begin
                    state_n = DONE;
                    grant_n = '0;
                    timer_en_n = 1'b0;
                    done_n = N_REQ'(1) << idx;
                end
            end
            ZERO: begin
                state_n = DONE;
                grant_n = '0;
                done_n = N_REQ'(1) << idx;
            end
            DONE: begin
                state_n = GAP;
                rr_n = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            end
            GAP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            rr_ptr <= '0;
            fin_q <= 1'b0;
            grant <= '0;
            done <= '0;
            timer_en <= 1'b0;
            remaining <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            rr_ptr <= rr_n;
            fin_q <= timer_finish;
            grant <= grant_n;
            done <= done_n;
            timer_en <= timer_en_n;
            remaining <= remaining_n;
            busy <= state_n != IDLE;
        end
    end
endmodule
